// File: rtl/spi_controller.sv
// SPI controller: one 16-bit mode-0 transaction per start, {rw,addr} then data.
// sclk is held low for IDLE_GAP cycles before done so the peripheral can reset.
module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int IDLE_GAP = 16
) (
    input  logic       iclk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       pico,
    input  logic       poci
);

    localparam int CMAX = (CLK_DIV > IDLE_GAP) ? CLK_DIV : IDLE_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END = CW'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] div_q;
    logic [3:0]    bit_q;
    logic [14:0]   tx_q;
    logic [7:0]    rx_q;
    logic          rw_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    rdata_q;
    logic          sclk_q;
    logic          pico_q;

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign pico  = pico_q;

    always_ff @(posedge iclk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
            sclk_q  <= 1'b0;
            pico_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    sclk_q <= 1'b0;
                    pico_q <= 1'b0;
                    if (start) begin
                        // bit 15 goes straight to pico; tx_q keeps the rest
                        tx_q    <= {addr, (rw ? wdata : 8'h00)};
                        rw_q    <= rw;
                        pico_q  <= rw;
                        busy_q  <= 1'b1;
                        div_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (div_q == DIV_END) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        rx_q    <= {rx_q[6:0], poci};
                        state_q <= S_SHIFT;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (div_q == DIV_END) begin
                        div_q <= '0;
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            if (bit_q == 4'd15) begin
                                pico_q  <= 1'b0;
                                state_q <= S_GAP;
                            end else begin
                                bit_q  <= bit_q + 4'd1;
                                pico_q <= tx_q[14];
                                tx_q   <= {tx_q[13:0], 1'b0};
                            end
                        end else begin
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[6:0], poci};
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (div_q == GAP_END) begin
                        div_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                        if (!rw_q) begin
                            rdata_q <= rx_q;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
